imem_loader_pipe: RTL and testbench

//  Parametrised instruction memory, successor to the single-cycle combinational IMEM.
//  - Fetch port: valid/ready request, registered read pipeline of RD_LAT cycles.
//  - Loader port: streams a program in from a boot loader via an FSM with an auto-incrementing pointer.
//  - Faults on misaligned or out-of-range PCs.
//  - Sits between the PC/IF stage and the decode stage.

---
 rtl/imem_loader_pipe.sv | 172 +++++++++++++++++
 tb/tb_imem_loader_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_pipe.sv
// imem_loader_pipe: instruction memory with a pipelined valid/ready fetch port
// and a streaming boot-loader write port driven by a two-state FSM.
// Optional feature macro: PARITY_EN (adds a stored even-parity bit per word
// and reports read parity errors on rsp_perr; tied 0 when undefined).
module imem_loader_pipe #(
    parameter int unsigned DATA      = 32,
    parameter int unsigned ADDR      = 32,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR-1:0]                req_pc,
    output logic                           rsp_valid,
    output logic [DATA-1:0]                rsp_instr,
    output logic                           rsp_fault,
    output logic                           rsp_perr,
    input  logic                           ld_start,
    input  logic [ADDR-1:0]                ld_base,
    input  logic                           ld_valid,
    input  logic [DATA-1:0]                ld_data,
    input  logic                           ld_last,
    output logic                           ld_busy,
    output logic [$clog2(MEM_DEPTH):0]     ld_count
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [DATA-1:0] NOP = DATA'(32'h0000_0013);

    typedef enum logic {
        IDLE,
        LOAD
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_en;

    logic [DATA-1:0]    mem [MEM_DEPTH];
`ifdef PARITY_EN
    logic               par_mem [MEM_DEPTH];
`endif

    // Fetch-side decode
    logic [ADDR-3:0]    req_word;
    logic [IDX_W-1:0]   req_idx;
    logic               req_fault;
    logic               accept;
    logic [DATA-1:0]    rd_word;
    logic               rd_perr;

    // Read pipeline: stage 0 is captured at the accept edge
    logic [RD_LAT-1:0]  pv_q, pv_d;
    logic [DATA-1:0]    pi_q [RD_LAT];
    logic [DATA-1:0]    pi_d [RD_LAT];
    logic               pf_q [RD_LAT];
    logic               pf_d [RD_LAT];
    logic               pp_q [RD_LAT];
    logic               pp_d [RD_LAT];

    assign req_ready = (state_q == IDLE) && !ld_start;
    assign ld_busy   = (state_q == LOAD);
    assign ld_count  = cnt_q;
    assign wr_en     = (state_q == LOAD) && ld_valid;

    assign req_word  = req_pc[ADDR-1:2];
    assign req_idx   = req_word[IDX_W-1:0];
    assign req_fault = (req_pc[1:0] != 2'b00) || ((req_word >> IDX_W) != '0);
    assign accept    = req_valid && req_ready;
    assign rd_word   = mem[req_idx];
`ifdef PARITY_EN
    assign rd_perr   = par_mem[req_idx] != (^rd_word);
`else
    assign rd_perr   = 1'b0;
`endif

    // Loader FSM next-state, write pointer and beat counter
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ld_start) begin
                    state_d = LOAD;
                    ptr_d   = ld_base[IDX_W+1:2];
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (ld_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Loader FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage array write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr_q]     <= ld_data;
`ifdef PARITY_EN
            par_mem[ptr_q] <= ^ld_data;
`endif
        end
    end

    // Read pipeline next values: faults never touch the array data
    always_comb begin
        pv_d    = '0;
        pv_d[0] = accept;
        pi_d[0] = pi_q[0];
        if (accept) begin
            pi_d[0] = req_fault ? NOP : rd_word;
        end
        pf_d[0] = accept && req_fault;
        pp_d[0] = accept && !req_fault && rd_perr;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pi_d[i] = pi_q[i-1];
            pf_d[i] = pf_q[i-1];
            pp_d[i] = pp_q[i-1];
        end
    end

    // Read pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pi_q[i] <= NOP;
                pf_q[i] <= 1'b0;
                pp_q[i] <= 1'b0;
            end
        end else begin
            pv_q <= pv_d;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pi_q[i] <= pi_d[i];
                pf_q[i] <= pf_d[i];
                pp_q[i] <= pp_d[i];
            end
        end
    end

    assign rsp_valid = pv_q[RD_LAT-1];
    assign rsp_instr = pi_q[RD_LAT-1];
    assign rsp_fault = pf_q[RD_LAT-1];
    assign rsp_perr  = pp_q[RD_LAT-1];

endmodule

// File: tb/tb_imem_loader_pipe.sv
// tb_imem_loader_pipe: four instances with RD_LAT=1..4 share one stimulus
// stream; a negedge monitor checks each lane's responses against a queue of
// accepted requests with bench-computed expected data.
`timescale 1ns/1ps
module tb_imem_loader_pipe;

    localparam int DEPTH = 16;
    localparam int LANES = 4;
`ifdef PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        ld_start;
    logic [31:0] ld_base;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;

    logic [LANES-1:0]       rdy;
    logic [LANES-1:0]       rv;
    logic [LANES-1:0][31:0] ri;
    logic [LANES-1:0]       rf;
    logic [LANES-1:0]       rp;
    logic [LANES-1:0]       busy;
    logic [LANES-1:0][4:0]  cnt;

    always #5 clk = ~clk;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        imem_loader_pipe #(
            .DATA(32), .ADDR(32), .MEM_DEPTH(DEPTH), .RD_LAT(g + 1)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid), .req_ready(rdy[g]), .req_pc(req_pc),
            .rsp_valid(rv[g]), .rsp_instr(ri[g]), .rsp_fault(rf[g]), .rsp_perr(rp[g]),
            .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid),
            .ld_data(ld_data), .ld_last(ld_last),
            .ld_busy(busy[g]), .ld_count(cnt[g])
        );
    end

    typedef struct {
        int          acc;
        logic [31:0] instr;
        logic        fault;
        logic        perr;
    } exp_t;

    exp_t        q[$];
    int          head [LANES];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model [DEPTH];
    int          perr_idx = -1;
    logic [31:0] drv_instr;
    logic        drv_fault;
    logic        drv_perr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor plus accept recorder
    always @(negedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (head[l] < q.size() && q[head[l]].acc + l == cyc) begin
                chk($sformatf("rsp_valid[%0d]", l), 32'(rv[l]), 32'd1);
                chk($sformatf("rsp_instr[%0d]", l), ri[l], q[head[l]].instr);
                chk($sformatf("rsp_fault[%0d]", l), 32'(rf[l]), 32'(q[head[l]].fault));
                chk($sformatf("rsp_perr[%0d]", l), 32'(rp[l]), 32'(q[head[l]].perr));
                head[l]++;
            end else begin
                chk($sformatf("rsp_idle[%0d]", l), 32'(rv[l]), 32'd0);
            end
        end
        if (rst_n && req_valid && rdy[0]) begin
            q.push_back('{cyc + 1, drv_instr, drv_fault, drv_perr});
        end
    end

    task automatic set_req(input logic [31:0] pc);
        int idx;
        idx       = int'(pc >> 2);
        drv_fault = (pc[1:0] != 2'b00) || (pc >= 32'(DEPTH * 4));
        drv_instr = drv_fault ? 32'h0000_0013 : model[idx];
        drv_perr  = !drv_fault && PAR && (idx == perr_idx);
        req_pc    = pc;
        req_valid = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        set_req(pc);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_words(input logic [31:0] base, input int n, input logic [31:0] seed);
        ld_base  = base;
        ld_start = 1'b1;
        #1;
        for (int l = 0; l < LANES; l++) chk("ready_on_start", 32'(rdy[l]), 32'd0);
        @(posedge clk); #1;
        ld_start = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            chk("busy_in_load", 32'(busy[l]), 32'd1);
            chk("count_at_start", 32'(cnt[l]), 32'd0);
            chk("ready_in_load", 32'(rdy[l]), 32'd0);
        end
        for (int k = 0; k < n; k++) begin
            ld_valid = 1'b1;
            ld_data  = seed + 32'(k);
            ld_last  = (k == n - 1);
            model[(int'(base >> 2) + k) % DEPTH] = seed + 32'(k);
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            chk("busy_after_last", 32'(busy[l]), 32'd0);
            chk("count_after_last", 32'(cnt[l]), 32'(n));
        end
    endtask

    task automatic reset_dut();
        @(negedge clk); #2;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        ld_start  = 1'b0;
        ld_valid  = 1'b0;
        ld_last   = 1'b0;
        for (int l = 0; l < LANES; l++) head[l] = q.size();
        #1;
        for (int l = 0; l < LANES; l++) begin
            chk("rst_valid", 32'(rv[l]), 32'd0);
            chk("rst_instr", ri[l], 32'h0000_0013);
            chk("rst_fault", 32'(rf[l]), 32'd0);
            chk("rst_perr", 32'(rp[l]), 32'd0);
            chk("rst_busy", 32'(busy[l]), 32'd0);
            chk("rst_count", 32'(cnt[l]), 32'd0);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_pc    = '0;
        ld_start  = 1'b0;
        ld_base   = '0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        ld_last   = 1'b0;
        drv_instr = '0;
        drv_fault = 1'b0;
        drv_perr  = 1'b0;
        for (int l = 0; l < LANES; l++) head[l] = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Power-up reset
        reset_dut();

        // Load A0..A3 at 0x10, fetch back-to-back
        load_words(32'h10, 4, 32'hA000_0000);
        fetch(32'h10);
        fetch(32'h14);
        fetch(32'h18);
        fetch(32'h1C);
        idle(6);

        // In-flight fetch completes with pre-load data; next fetch sees new data
        fetch(32'h10);
        load_words(32'h10, 1, 32'hB000_0000);
        fetch(32'h10);
        idle(6);

        // Pointer wrap across the end of the array
        load_words(32'((DEPTH - 1) * 4), 3, 32'h5A5A_0000);
        fetch(32'((DEPTH - 1) * 4));
        fetch(32'h0);
        fetch(32'h4);
        idle(6);

        // Misaligned and out-of-range addresses
        fetch(32'h6);
        fetch(32'(DEPTH * 4));
        fetch(32'h3);
        idle(6);

        // ld_start and req_valid together: load wins, fetch waits for IDLE
        set_req(32'h20);
        load_words(32'h20, 2, 32'hC0DE_0000);
        set_req(32'h20);
        @(posedge clk); #1;
        req_valid = 1'b0;
        idle(6);

        // Reset after 2 of 5 beats
        ld_base  = 32'h10;
        ld_start = 1'b1;
        @(posedge clk); #1;
        ld_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hD000_0000 + 32'(k);
            ld_last  = 1'b0;
            model[4 + k] = 32'hD000_0000 + 32'(k);
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        for (int l = 0; l < LANES; l++) chk("count_mid_burst", 32'(cnt[l]), 32'd2);
        reset_dut();
        fetch(32'h10);
        fetch(32'h14);
        fetch(32'h18);
        idle(6);

        // Reset with a fetch in flight drops it
        fetch(32'h14);
        reset_dut();
        fetch(32'h18);
        idle(6);

        // Parity: corrupt one data bit of word 3 behind the loader's back
        load_words(32'hC, 1, 32'h3C3C_0001);
        g_lane[0].u_dut.mem[3] = g_lane[0].u_dut.mem[3] ^ 32'h1;
        g_lane[1].u_dut.mem[3] = g_lane[1].u_dut.mem[3] ^ 32'h1;
        g_lane[2].u_dut.mem[3] = g_lane[2].u_dut.mem[3] ^ 32'h1;
        g_lane[3].u_dut.mem[3] = g_lane[3].u_dut.mem[3] ^ 32'h1;
        model[3] = model[3] ^ 32'h1;
        perr_idx = 3;
        fetch(32'hC);
        idle(8);

        for (int l = 0; l < LANES; l++) chk($sformatf("drained[%0d]", l), 32'(head[l]), 32'(q.size()));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
